// File: rtl/mem_pkg.sv
// Shared types and default sizing for the mem_pipe block.
package mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;
  localparam int RD_LAT_DEF = 1;

  // Request FSM: IDLE accepts, RD_WAIT burns extra read latency, RESP drives the read result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; callers only present in-range addresses.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_pipe.sv
// Single-port memory front end with fixed read latency, range checking and a done pulse.
module mem_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              oor_q, oor_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic              addr_ok;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // DEPTH can equal 2**ADDR_W, so compare one bit wider.
  assign addr_ok = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign ready   = (state_q == IDLE);
  // A request seen while reset is low must not touch the array.
  assign accept  = req && ready && rst_n;
  assign mem_we  = accept && we && addr_ok;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr[AW-1:0]),
    .wdata (wdata),
    .raddr (addr_q),
    .rdata (mem_rd)
  );

  // Next-state: writes complete from IDLE, reads walk RD_WAIT (if needed) then RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (we) begin
            done_d = 1'b1;
            err_d  = !addr_ok;
          end else begin
            addr_d = addr[AW-1:0];
            oor_d  = !addr_ok;
            if (RD_LAT == 1) begin
              state_d = RESP;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = CW'(1);
            end
          end
        end
      end
      RD_WAIT: begin
        // Counter saturates at RD_LAT-1 by construction; no wrap path.
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        err_d   = oor_q;
        rdata_d = oor_q ? '0 : mem_rd;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_pipe.sv
// Scoreboard bench for mem_pipe across several latency/depth configurations.
module tb_mem_pipe;

  localparam int N = 5;
  localparam int LAT [N] = '{1, 3, 1, 4, 2};
  localparam int DEP [N] = '{32, 32, 24, 32, 32};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [N];
  logic       req   [N];
  logic       we    [N];
  logic [4:0] addr  [N];
  logic [7:0] wdata [N];
  logic       ready [N];
  logic       done  [N];
  logic       err   [N];
  logic [7:0] rdata [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_pipe #(
      .DATA_W (8),
      .ADDR_W (5),
      .DEPTH  (DEP[g]),
      .RD_LAT (LAT[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .req   (req[g]),
      .we    (we[g]),
      .addr  (addr[g]),
      .wdata (wdata[g]),
      .ready (ready[g]),
      .done  (done[g]),
      .rdata (rdata[g]),
      .err   (err[g])
    );
  end

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       rd;
    int         cyc;
  } exp_t;

  exp_t       sb   [N][$];
  logic [7:0] mdl  [N][32];
  logic [7:0] held [N];
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  bit         armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Output monitor: every done pops one expectation; idle cycles keep err low and rdata held.
  always @(negedge clk) begin : mon
    exp_t e;
    if (armed) begin
      for (int k = 0; k < N; k++) begin
        if (done[k] === 1'b1) begin
          if (sb[k].size() == 0) begin
            chk($sformatf("u%0d.spurious_done", k), 1, 0);
          end else begin
            e = sb[k].pop_front();
            chk($sformatf("u%0d.done_cyc", k), cyc, e.cyc);
            chk($sformatf("u%0d.err", k), {31'b0, err[k]}, {31'b0, e.e});
            if (e.rd) begin
              chk($sformatf("u%0d.rdata", k), {24'b0, rdata[k]}, {24'b0, e.d});
              held[k] = e.d;
            end else begin
              chk($sformatf("u%0d.wr_rdata_hold", k), {24'b0, rdata[k]}, {24'b0, held[k]});
            end
          end
        end else begin
          chk($sformatf("u%0d.idle_done", k), {31'b0, done[k]}, 0);
          chk($sformatf("u%0d.idle_err", k), {31'b0, err[k]}, 0);
          chk($sformatf("u%0d.rdata_hold", k), {24'b0, rdata[k]}, {24'b0, held[k]});
        end
        if (rst_n[k] !== 1'b1) held[k] = 8'h00;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for ready, present one request for one edge, record its expected response.
  task automatic issue(input int k, input bit w, input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    int   n = 0;
    while (ready[k] !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    if (ready[k] !== 1'b1) begin
      chk($sformatf("u%0d.ready_timeout", k), 0, 1);
      return;
    end
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    e.rd  = !w;
    e.e   = (int'(a) >= DEP[k]);
    e.cyc = cyc + 1 + (w ? 0 : LAT[k]);
    if (w) begin
      e.d = 8'h00;
      if (!e.e) mdl[k][a] = d;
    end else begin
      e.d = e.e ? 8'h00 : mdl[k][a];
    end
    sb[k].push_back(e);
    step(1);
    req[k] = 1'b0;
  endtask

  initial begin : stim
    exp_t e;
    int   n;
    bit   pend;
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      req[k]   = 1'b0;
      we[k]    = 1'b0;
      addr[k]  = 5'd0;
      wdata[k] = 8'h00;
      held[k]  = 8'h00;
    end
    step(3);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d.rst_ready", k), {31'b0, ready[k]}, 1);
      chk($sformatf("u%0d.rst_done", k), {31'b0, done[k]}, 0);
      chk($sformatf("u%0d.rst_err", k), {31'b0, err[k]}, 0);
      chk($sformatf("u%0d.rst_rdata", k), {24'b0, rdata[k]}, 0);
      rst_n[k] = 1'b1;
    end
    armed = 1'b1;

    // Defaults: basic write/read, boundary address, back-to-back writes.
    issue(0, 1'b1, 5'd0, 8'hAA);
    issue(0, 1'b0, 5'd0, 8'h00);
    issue(0, 1'b1, 5'd15, 8'hF0);
    issue(0, 1'b0, 5'd15, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("u0.b2b_ready", {31'b0, ready[0]}, 1);
      issue(0, 1'b1, 5'(i + 1), 8'(16 + i));
    end
    issue(0, 1'b0, 5'd3, 8'h00);
    issue(0, 1'b1, 5'd31, 8'hC3);
    issue(0, 1'b0, 5'd31, 8'h00);
    issue(0, 1'b0, 5'd1, 8'h00);

    // DEPTH=24: out-of-range write must not alias into the array.
    issue(2, 1'b1, 5'd1, 8'h22);
    issue(2, 1'b1, 5'd25, 8'h11);
    issue(2, 1'b0, 5'd25, 8'h00);
    issue(2, 1'b0, 5'd1, 8'h00);
    issue(2, 1'b1, 5'd23, 8'h5A);
    issue(2, 1'b0, 5'd23, 8'h00);
    issue(2, 1'b0, 5'd24, 8'h00);

    // RD_LAT=3 with req held high: busy for 3 cycles, second read taken after RESP.
    issue(1, 1'b1, 5'd7, 8'h5C);
    chk("u1.ready_pre", {31'b0, ready[1]}, 1);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd7;
    e.d = 8'h5C; e.e = 1'b0; e.rd = 1'b1; e.cyc = cyc + 1 + 3;
    sb[1].push_back(e);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("u1.busy_ready", {31'b0, ready[1]}, 0);
    end
    step(1);
    chk("u1.ready_after_resp", {31'b0, ready[1]}, 1);
    e.cyc = cyc + 1 + 3;
    sb[1].push_back(e);
    step(1);
    req[1] = 1'b0;

    // RD_LAT=2: address/op changes during RD_WAIT must not affect the read in flight.
    issue(4, 1'b1, 5'd3, 8'h33);
    issue(4, 1'b1, 5'd9, 8'h99);
    issue(4, 1'b0, 5'd3, 8'h00);
    addr[4] = 5'd9; we[4] = 1'b1; wdata[4] = 8'hFF;
    step(3);
    issue(4, 1'b0, 5'd9, 8'h00);

    // RD_LAT=4: reset mid-read aborts it; a write presented during reset is dropped.
    issue(3, 1'b1, 5'd2, 8'h77);
    issue(3, 1'b0, 5'd2, 8'h00);
    step(1);
    rst_n[3] = 1'b0; req[3] = 1'b1; we[3] = 1'b1; addr[3] = 5'd2; wdata[3] = 8'hEE;
    sb[3].delete();
    step(1);
    rst_n[3] = 1'b1; req[3] = 1'b0;
    chk("u3.ready_after_rst", {31'b0, ready[3]}, 1);
    chk("u3.done_after_rst", {31'b0, done[3]}, 0);
    step(8);
    issue(3, 1'b0, 5'd2, 8'h00);

    // Drain outstanding responses with a bounded wait.
    n = 0;
    do begin
      pend = 1'b0;
      for (int k = 0; k < N; k++) if (sb[k].size() != 0) pend = 1'b1;
      if (pend) step(1);
      n++;
    end while (pend && n < 100);
    for (int k = 0; k < N; k++)
      chk($sformatf("u%0d.drain", k), sb[k].size(), 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
